board_mem_arbiter: RTL and testbench

- Arbitrates the single-port board-state RAM (one 2-bit cell per board intersection) between two requesters: the VGA pixel path and the game-logic command stream.
- Video reads always win, so video timing is never disturbed.
- Game-logic reads and writes are queued in a small FIFO and issued only on cycles the video path leaves idle.
- Also sequences a whole-board clear, so the board can be reset without tearing the displayed frame.

---
 rtl/board_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_board_mem_arbiter.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : board_mem_arbiter
// Description : Shares the single-port board-state RAM (one CELL_BITS cell
//               per intersection) between the VGA pixel path and the
//               game-logic command stream. Video reads always own the port.
//               Game commands are queued and issued on idle cycles. A
//               whole-board clear is sequenced so the displayed frame never
//               tears.
// Ports       : clk, rst (async, active-low)
//               vid_*   : video read request / registered read return
//               gl_*    : game command (valid/ready) and read return
//               clr_*   : whole-board clear request / busy flag
//               err_oor : sticky out-of-range command flag
//               mem_*   : RAM port (synchronous read, 1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module board_mem_arbiter #(
    parameter int CELL_BITS  = 2,
    parameter int ADDR_W     = 8,
    parameter int NUM_CELLS  = 225,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vid_active,
    input  logic                 vid_rd_en,
    input  logic [ADDR_W-1:0]    vid_rd_addr,
    output logic                 vid_rd_vld,
    output logic [CELL_BITS-1:0] vid_rd_data,
    input  logic                 gl_valid,
    output logic                 gl_ready,
    input  logic                 gl_we,
    input  logic [ADDR_W-1:0]    gl_addr,
    input  logic [CELL_BITS-1:0] gl_wdata,
    output logic                 gl_rvalid,
    output logic [CELL_BITS-1:0] gl_rdata,
    input  logic                 clr_req,
    output logic                 clr_busy,
    output logic                 err_oor,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_we,
    output logic [CELL_BITS-1:0] mem_wdata,
    input  logic [CELL_BITS-1:0] mem_rdata
);

    // FIFO_DEPTH is a power of two >= 2, so pointers wrap naturally.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(NUM_CELLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     clr_cnt_q, clr_cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  fifo_we_q    [FIFO_DEPTH];
    logic                  fifo_we_d    [FIFO_DEPTH];
    logic [ADDR_W-1:0]     fifo_addr_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0]     fifo_addr_d  [FIFO_DEPTH];
    logic [CELL_BITS-1:0]  fifo_wdata_q [FIFO_DEPTH];
    logic [CELL_BITS-1:0]  fifo_wdata_d [FIFO_DEPTH];
    logic                  vid_rd_vld_q, vid_rd_vld_d;
    logic                  gl_rd_pend_q, gl_rd_pend_d;
    logic                  gl_rd_oor_q, gl_rd_oor_d;
    logic                  err_oor_q, err_oor_d;

    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  port_free;
    logic                  accept;
    logic                  issue;
    logic                  clr_grant;
    logic                  head_we;
    logic [ADDR_W-1:0]     head_addr;
    logic [CELL_BITS-1:0]  head_wdata;
    logic                  head_oor;

    // ------------------------------------------------------------------
    // Arbitration decisions
    // ------------------------------------------------------------------
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    // Port is available to game/clear only when video neither reads nor
    // is inside the display region.
    assign port_free  = !vid_rd_en && !vid_active;
    assign clr_busy   = (state_q != ST_IDLE);
    // Ready is based on start-of-cycle occupancy; no bypass path exists.
    assign gl_ready   = !fifo_full && !clr_busy;
    assign accept     = gl_valid && gl_ready;
    assign issue      = port_free && !fifo_empty && (state_q != ST_CLEAR);
    assign clr_grant  = port_free && (state_q == ST_CLEAR);

    assign head_we    = fifo_we_q[rd_ptr_q];
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_wdata = fifo_wdata_q[rd_ptr_q];
    assign head_oor   = (head_addr > LAST_CELL);

    // ------------------------------------------------------------------
    // RAM port mux; held at zero while reset is asserted
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (rst) begin
            if (vid_rd_en) begin
                mem_addr = vid_rd_addr;
            end else if (vid_active) begin
                mem_addr = '0;
            end else if (state_q == ST_CLEAR) begin
                mem_addr = clr_cnt_q;
                mem_we   = 1'b1;
            end else if (issue) begin
                mem_addr  = head_addr;
                mem_we    = head_we && !head_oor;
                mem_wdata = head_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    always_comb begin
        fifo_we_d    = fifo_we_q;
        fifo_addr_d  = fifo_addr_q;
        fifo_wdata_d = fifo_wdata_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (accept) begin
            fifo_we_d[wr_ptr_q]    = gl_we;
            fifo_addr_d[wr_ptr_q]  = gl_addr;
            fifo_wdata_d[wr_ptr_q] = gl_wdata;
            wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({accept, issue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // No accepts while busy, so count_d==0 means the last
                // queued command has issued (or the queue was empty).
                if (count_d == '0) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_grant) begin
                    if (clr_cnt_q == LAST_CELL) begin
                        state_d   = ST_IDLE;
                        clr_cnt_d = '0;
                    end else begin
                        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read-return tracking and sticky error
    // ------------------------------------------------------------------
    always_comb begin
        vid_rd_vld_d = vid_rd_en;
        gl_rd_pend_d = issue && !head_we;
        gl_rd_oor_d  = issue && !head_we && head_oor;
        err_oor_d    = err_oor_q || (issue && head_oor);
    end

    assign vid_rd_vld  = vid_rd_vld_q;
    assign vid_rd_data = vid_rd_vld_q ? mem_rdata : '0;
    assign gl_rvalid   = gl_rd_pend_q;
    assign gl_rdata    = (gl_rd_pend_q && !gl_rd_oor_q) ? mem_rdata : '0;
    assign err_oor     = err_oor_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            vid_rd_vld_q <= 1'b0;
            gl_rd_pend_q <= 1'b0;
            gl_rd_oor_q  <= 1'b0;
            err_oor_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_we_q[i]    <= 1'b0;
                fifo_addr_q[i]  <= '0;
                fifo_wdata_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            vid_rd_vld_q <= vid_rd_vld_d;
            gl_rd_pend_q <= gl_rd_pend_d;
            gl_rd_oor_q  <= gl_rd_oor_d;
            err_oor_q    <= err_oor_d;
            fifo_we_q    <= fifo_we_d;
            fifo_addr_q  <= fifo_addr_d;
            fifo_wdata_q <= fifo_wdata_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_board_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_mem_arbiter
// Description : Self-checking bench for board_mem_arbiter. A RAM model sits
//               on the mem_* port; a monitor pushes expected RAM writes and
//               game read data when handshakes occur and pops them when the
//               DUT produces them. A vector table covers video ownership;
//               directed sequences cover queueing, clear and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vid_active, vid_rd_en;
    logic [7:0] vid_rd_addr;
    logic       vid_rd_vld;
    logic [1:0] vid_rd_data;
    logic       gl_valid, gl_ready, gl_we;
    logic [7:0] gl_addr;
    logic [1:0] gl_wdata;
    logic       gl_rvalid;
    logic [1:0] gl_rdata;
    logic       clr_req, clr_busy, err_oor;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [1:0] mem_wdata;
    logic [1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    board_mem_arbiter #(
        .CELL_BITS (2),
        .ADDR_W    (8),
        .NUM_CELLS (225),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .vid_active (vid_active),
        .vid_rd_en  (vid_rd_en),
        .vid_rd_addr(vid_rd_addr),
        .vid_rd_vld (vid_rd_vld),
        .vid_rd_data(vid_rd_data),
        .gl_valid   (gl_valid),
        .gl_ready   (gl_ready),
        .gl_we      (gl_we),
        .gl_addr    (gl_addr),
        .gl_wdata   (gl_wdata),
        .gl_rvalid  (gl_rvalid),
        .gl_rdata   (gl_rdata),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .err_oor    (err_oor),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Synchronous single-port RAM model
    logic [1:0] ram [256];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) ram[i] <= 2'd0;
            mem_rdata <= 2'd0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard monitor (samples on the falling edge)
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [7:0] addr;
        logic [1:0] data;
    } wr_t;

    wr_t        exp_wr_q [$];
    logic [1:0] exp_rd_q [$];
    logic [1:0] ref_mem  [256];

    initial begin : monitor
        logic       prev_en;
        logic [1:0] prev_exp;
        wr_t        w;
        logic [1:0] r;
        prev_en  = 1'b0;
        prev_exp = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_en = 1'b0;
                exp_wr_q.delete();
                exp_rd_q.delete();
                for (int i = 0; i < 256; i++) ref_mem[i] = 2'd0;
            end else begin
                if (prev_en || vid_rd_vld) begin
                    chk("vid_rd_vld", int'(vid_rd_vld), int'(prev_en));
                    chk("vid_rd_data", int'(vid_rd_data), prev_en ? int'(prev_exp) : 0);
                end
                if (vid_rd_en) begin
                    chk("vid_owns_addr", int'(mem_addr), int'(vid_rd_addr));
                    chk("vid_owns_we", int'(mem_we), 0);
                end
                prev_en  = vid_rd_en;
                prev_exp = ram[vid_rd_addr];
                if (mem_we) begin
                    chk("we_during_video", int'(vid_active | vid_rd_en), 0);
                    if (exp_wr_q.size() == 0) begin
                        chk("unexpected_write_addr", int'(mem_addr), -1);
                    end else begin
                        w = exp_wr_q.pop_front();
                        chk("write_addr", int'(mem_addr), int'(w.addr));
                        chk("write_data", int'(mem_wdata), int'(w.data));
                    end
                end
                if (gl_rvalid) begin
                    if (exp_rd_q.size() == 0) begin
                        chk("unexpected_rvalid", int'(gl_rdata), -1);
                    end else begin
                        r = exp_rd_q.pop_front();
                        chk("gl_rdata", int'(gl_rdata), int'(r));
                    end
                end
                // Handshakes seen now complete at the next rising edge.
                if (gl_valid && gl_ready) begin
                    if (gl_we) begin
                        if (gl_addr < 8'd225) begin
                            w.addr = gl_addr;
                            w.data = gl_wdata;
                            exp_wr_q.push_back(w);
                            ref_mem[gl_addr] = gl_wdata;
                        end
                    end else begin
                        exp_rd_q.push_back((gl_addr < 8'd225) ? ref_mem[gl_addr] : 2'd0);
                    end
                end
                if (clr_req && !clr_busy) begin
                    for (int i = 0; i < 225; i++) begin
                        w.addr = 8'(i);
                        w.data = 2'd0;
                        exp_wr_q.push_back(w);
                        ref_mem[i] = 2'd0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command and returns just after the accepting edge.
    task automatic send(input logic we, input logic [7:0] a, input logic [1:0] d);
        logic ok;
        ok       = 1'b0;
        gl_valid = 1'b1;
        gl_we    = we;
        gl_addr  = a;
        gl_wdata = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = gl_ready;
            tick();
        end
        gl_valid = 1'b0;
        chk("send_accepted", int'(ok), 1);
    endtask

    typedef struct packed {
        logic       en;
        logic       act;
        logic [7:0] addr;
        logic       exp_we;
        logic [7:0] exp_addr;
        logic       exp_vld;
        logic [1:0] exp_data;
    } vec_t;

    vec_t vecs [6];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Main test sequence
    // ------------------------------------------------------------------
    initial begin : main
        int cnt_bad, we_bad, busy_we, last224, done_at, k;
        logic acc5;

        vecs[0] = '{1'b1, 1'b0, 8'd112, 1'b0, 8'd112, 1'b1, 2'd2};
        vecs[1] = '{1'b1, 1'b1, 8'd112, 1'b0, 8'd112, 1'b1, 2'd2};
        vecs[2] = '{1'b0, 1'b0, 8'd33,  1'b0, 8'd0,   1'b0, 2'd0};
        vecs[3] = '{1'b0, 1'b1, 8'd99,  1'b0, 8'd0,   1'b0, 2'd0};
        vecs[4] = '{1'b1, 1'b0, 8'd224, 1'b0, 8'd224, 1'b1, 2'd0};
        vecs[5] = '{1'b1, 1'b1, 8'd0,   1'b0, 8'd0,   1'b1, 2'd0};

        rst_n = 1'b0; vid_active = 1'b0; vid_rd_en = 1'b0; vid_rd_addr = 8'd0;
        gl_valid = 1'b0; gl_we = 1'b0; gl_addr = 8'd0; gl_wdata = 2'd0; clr_req = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vid_rd_vld", int'(vid_rd_vld), 0);
        chk("rst_gl_rvalid", int'(gl_rvalid), 0);
        chk("rst_clr_busy", int'(clr_busy), 0);
        chk("rst_err_oor", int'(err_oor), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", int'(gl_ready), 1);
        tick();

        // 1: write issues the cycle after acceptance
        send(1'b1, 8'd112, 2'd2);
        @(negedge clk);
        chk("t1_mem_we", int'(mem_we), 1);
        chk("t1_mem_addr", int'(mem_addr), 112);
        chk("t1_mem_wdata", int'(mem_wdata), 2);
        repeat (2) tick();

        // Video ownership vector table (FIFO empty, no clear)
        foreach (vecs[i]) begin
            tick();
            vid_rd_en = vecs[i].en; vid_active = vecs[i].act; vid_rd_addr = vecs[i].addr;
            @(negedge clk);
            chk("vec_mem_we", int'(mem_we), int'(vecs[i].exp_we));
            chk("vec_mem_addr", int'(mem_addr), int'(vecs[i].exp_addr));
            chk("vec_gl_ready", int'(gl_ready), 1);
            tick();
            vid_rd_en = 1'b0; vid_active = 1'b0; vid_rd_addr = 8'd0;
            @(negedge clk);
            chk("vec_rd_vld", int'(vid_rd_vld), int'(vecs[i].exp_vld));
            chk("vec_rd_data", int'(vid_rd_data), int'(vecs[i].exp_data));
        end
        tick();

        // 2: queue fills during display region, drains afterwards in order
        vid_active = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b1, 8'(10 + i), 2'(1 + (i % 2)));
        gl_valid = 1'b1; gl_we = 1'b1; gl_addr = 8'd14; gl_wdata = 2'd1;
        cnt_bad = 0; we_bad = 0;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            if (gl_ready) cnt_bad++;
            if (mem_we) we_bad++;
            tick();
        end
        chk("t2_ready_low_when_full", cnt_bad, 0);
        chk("t2_no_we_while_active", we_bad, 0);
        vid_active = 1'b0;
        acc5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_drain_we", int'(mem_we), 1);
            chk("t2_drain_addr", int'(mem_addr), 10 + i);
            if (gl_valid && gl_ready) acc5 = 1'b1;
            tick();
            if (acc5) gl_valid = 1'b0;
        end
        chk("t2_fifth_accepted", int'(acc5), 1);
        gl_valid = 1'b0;
        tick();

        // 3: video reads stall a queued write
        vid_active = 1'b1;
        send(1'b1, 8'd20, 2'd2);
        vid_active = 1'b0; vid_rd_en = 1'b1; vid_rd_addr = 8'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_vid_addr", int'(mem_addr), 7);
            chk("t3_vid_we", int'(mem_we), 0);
            tick();
        end
        vid_rd_en = 1'b0;
        @(negedge clk);
        chk("t3_write_after_video", int'(mem_we), 1);
        chk("t3_write_addr", int'(mem_addr), 20);
        repeat (2) tick();

        // 4: write then read of the same cell
        send(1'b1, 8'd5, 2'd1);
        send(1'b0, 8'd5, 2'd0);
        @(negedge clk);
        chk("t4_read_issue_addr", int'(mem_addr), 5);
        chk("t4_read_issue_we", int'(mem_we), 0);
        chk("t4_rvalid_not_yet", int'(gl_rvalid), 0);
        tick();
        @(negedge clk);
        chk("t4_rvalid", int'(gl_rvalid), 1);
        chk("t4_rdata", int'(gl_rdata), 1);
        tick();
        @(negedge clk);
        chk("t4_rvalid_pulse", int'(gl_rvalid), 0);
        tick();

        // 6a: out-of-range write and read
        send(1'b1, 8'd230, 2'd1);
        @(negedge clk);
        chk("t6_oor_no_we", int'(mem_we), 0);
        tick();
        @(negedge clk);
        chk("t6_err_set", int'(err_oor), 1);
        tick();
        send(1'b0, 8'd240, 2'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("t6_err_held", int'(err_oor), 1);
        tick();

        // 5a: clear after draining two queued writes, video idle
        vid_active = 1'b1;
        send(1'b1, 8'd30, 2'd1);
        send(1'b1, 8'd31, 2'd2);
        vid_active = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt_bad = 0; busy_we = 0; last224 = -100; done_at = -1;
        for (int i = 0; i < 600 && done_at < 0; i++) begin
            @(negedge clk);
            if (clr_busy) begin
                if (gl_ready) cnt_bad++;
                if (mem_we) busy_we++;
                if (mem_we && mem_addr == 8'd224) last224 = i;
            end else begin
                done_at = i;
            end
            tick();
        end
        chk("t5_ready_low_busy", cnt_bad, 0);
        chk("t5_busy_writes", busy_we, 226);
        chk("t5_busy_falls_after_224", done_at, last224 + 1);

        // 5b: clear with video toggling
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_we = 0; last224 = -100; done_at = -1; k = 0;
        for (int i = 0; i < 1200 && done_at < 0; i++) begin
            vid_active = (i % 3 == 0);
            @(negedge clk);
            if (clr_busy) begin
                k++;
                if (mem_we) busy_we++;
                if (mem_we && mem_addr == 8'd224) last224 = i;
            end else begin
                done_at = i;
            end
            tick();
        end
        vid_active = 1'b0;
        chk("t5b_clear_writes", busy_we, 225);
        chk("t5b_busy_falls_after_224", done_at, last224 + 1);
        chk("t5b_stalled", int'(k > 300), 1);
        chk("sb_writes_drained", exp_wr_q.size(), 0);
        chk("sb_reads_drained", exp_rd_q.size(), 0);
        tick();

        // 6b: reset in the middle of a clear
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        k = 0;
        for (int i = 0; i < 400 && k == 0; i++) begin
            @(negedge clk);
            if (mem_we && mem_addr == 8'd50) k = 1;
            else tick();
        end
        chk("t6_reached_cnt50", k, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_clr_busy", int'(clr_busy), 0);
        chk("t6_rst_mem_we", int'(mem_we), 0);
        chk("t6_rst_err_oor", int'(err_oor), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        we_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_we || clr_busy) we_bad++;
            if (i == 0) chk("t6_ready_after_release", int'(gl_ready), 1);
            tick();
        end
        chk("t6_no_work_after_reset", we_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
